// File: rtl/rgb_extrema_pipe_pkg.sv
// Shared definitions for the RGB extrema pipeline: channel-select encoding and default width.
package rgb_extrema_pipe_pkg;

    localparam int unsigned DEFAULT_W = 8;

    typedef enum logic [1:0] {
        SEL_R = 2'd0,
        SEL_G = 2'd1,
        SEL_B = 2'd2
    } sel_e;

endpackage

// File: rtl/rgb_extrema_pipe_if.sv
// Pixel-in / result-out stream bundle for rgb_extrema_pipe.
interface rgb_extrema_pipe_if
    import rgb_extrema_pipe_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_r;
    logic [W-1:0] in_g;
    logic [W-1:0] in_b;
    logic         in_sof;
    logic         in_eof;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_max;
    logic [W-1:0] out_min;
    logic [W-1:0] out_delta;
    logic [W:0]   out_rg;
    logic [W:0]   out_gb;
    logic [W:0]   out_br;
    logic [1:0]   out_sel;
    logic         out_sof;
    logic         out_eof;

    modport master (
        output in_valid, in_r, in_g, in_b, in_sof, in_eof, out_ready,
        input  in_ready, out_valid, out_max, out_min, out_delta,
               out_rg, out_gb, out_br, out_sel, out_sof, out_eof
    );

    modport slave (
        input  in_valid, in_r, in_g, in_b, in_sof, in_eof, out_ready,
        output in_ready, out_valid, out_max, out_min, out_delta,
               out_rg, out_gb, out_br, out_sel, out_sof, out_eof
    );

endinterface

// File: rtl/rgb_pipe_stage.sv
// Generic valid/ready register slice: loads when empty or when its content moves on.
module rgb_pipe_stage #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/rgb_extrema_pipe.sv
// Two-stage RGB max/min/difference pipeline with optional per-frame extrema statistics.
module rgb_extrema_pipe
    import rgb_extrema_pipe_pkg::*;
#(
    parameter int unsigned W        = DEFAULT_W,
    parameter bit          STATS_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    rgb_extrema_pipe_if.slave   bus,
    output logic [W-1:0]        frame_max,
    output logic [W-1:0]        frame_min,
    output logic                frame_done
);

    typedef struct packed {
        logic [W:0]   rg;
        logic [W:0]   gb;
        logic [W:0]   br;
        logic [W-1:0] max_pick;
        logic         max_is_g;
        logic [W-1:0] min_pick;
        logic [W-1:0] b;
        logic         sof;
        logic         eof;
    } s1_t;

    typedef struct packed {
        logic [W-1:0] mx;
        logic [W-1:0] mn;
        logic [W-1:0] delta;
        logic [W:0]   rg;
        logic [W:0]   gb;
        logic [W:0]   br;
        sel_e         sel;
        logic         sof;
        logic         eof;
    } s2_t;

    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    logic s1_valid;
    logic s2_in_ready;

    // Stage 1: zero-extended differences plus the R-vs-G candidates; B is resolved in stage 2.
    always_comb begin
        s1_d          = '0;
        s1_d.rg       = {1'b0, bus.in_r} - {1'b0, bus.in_g};
        s1_d.gb       = {1'b0, bus.in_g} - {1'b0, bus.in_b};
        s1_d.br       = {1'b0, bus.in_b} - {1'b0, bus.in_r};
        s1_d.max_is_g = !(bus.in_r >= bus.in_g);
        s1_d.max_pick = s1_d.max_is_g ? bus.in_g : bus.in_r;
        s1_d.min_pick = (bus.in_r < bus.in_g) ? bus.in_r : bus.in_g;
        s1_d.b        = bus.in_b;
        s1_d.sof      = bus.in_sof;
        s1_d.eof      = bus.in_eof;
    end

    rgb_pipe_stage #(.DW($bits(s1_t))) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (s1_d),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_q)
    );

    always_comb begin
        s2_d    = '0;
        s2_d.rg = s1_q.rg;
        s2_d.gb = s1_q.gb;
        s2_d.br = s1_q.br;
        if (s1_q.max_pick >= s1_q.b) begin
            s2_d.mx  = s1_q.max_pick;
            s2_d.sel = s1_q.max_is_g ? SEL_G : SEL_R;
        end else begin
            s2_d.mx  = s1_q.b;
            s2_d.sel = SEL_B;
        end
        s2_d.mn    = (s1_q.min_pick < s1_q.b) ? s1_q.min_pick : s1_q.b;
        s2_d.delta = s2_d.mx - s2_d.mn;
        s2_d.sof   = s1_q.sof;
        s2_d.eof   = s1_q.eof;
    end

    rgb_pipe_stage #(.DW($bits(s2_t))) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   (s2_d),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (s2_q)
    );

    assign bus.out_max   = s2_q.mx;
    assign bus.out_min   = s2_q.mn;
    assign bus.out_delta = s2_q.delta;
    assign bus.out_rg    = s2_q.rg;
    assign bus.out_gb    = s2_q.gb;
    assign bus.out_br    = s2_q.br;
    assign bus.out_sel   = s2_q.sel;
    assign bus.out_sof   = s2_q.sof;
    assign bus.out_eof   = s2_q.eof;

    generate
        if (STATS_EN) begin : g_stats
            logic [W-1:0] acc_max, acc_min;
            logic [W-1:0] nxt_max, nxt_min;
            logic         xfer;

            assign xfer = bus.out_valid && bus.out_ready;

            // sof restarts the running extrema from the current pixel.
            always_comb begin
                nxt_max = acc_max;
                nxt_min = acc_min;
                if (bus.out_sof) begin
                    nxt_max = bus.out_max;
                    nxt_min = bus.out_min;
                end else begin
                    if (bus.out_max > acc_max) nxt_max = bus.out_max;
                    if (bus.out_min < acc_min) nxt_min = bus.out_min;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_max    <= '0;
                    acc_min    <= '0;
                    frame_max  <= '0;
                    frame_min  <= '0;
                    frame_done <= 1'b0;
                end else begin
                    frame_done <= xfer && bus.out_eof;
                    if (xfer) begin
                        acc_max <= nxt_max;
                        acc_min <= nxt_min;
                        if (bus.out_eof) begin
                            frame_max <= nxt_max;
                            frame_min <= nxt_min;
                        end
                    end
                end
            end
        end else begin : g_no_stats
            assign frame_max  = '0;
            assign frame_min  = '0;
            assign frame_done = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_rgb_extrema_pipe.sv
// Directed self-checking bench for rgb_extrema_pipe (W=8 main instance, W=12 extremes instance).
module tb_rgb_extrema_pipe;
    import rgb_extrema_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rgb_extrema_pipe_if #(.W(8))  bus ();
    rgb_extrema_pipe_if #(.W(12)) bus12 ();

    logic [7:0]  frame_max, frame_min;
    logic        frame_done;
    logic [11:0] frame_max12, frame_min12;
    logic        frame_done12;

    rgb_extrema_pipe #(.W(8), .STATS_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .frame_max  (frame_max),
        .frame_min  (frame_min),
        .frame_done (frame_done)
    );

    rgb_extrema_pipe #(.W(12), .STATS_EN(1'b1)) dut12 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus12),
        .frame_max  (frame_max12),
        .frame_min  (frame_min12),
        .frame_done (frame_done12)
    );

    typedef struct {
        logic [7:0]  mx, mn, dl;
        logic [8:0]  rg, gb, br;
        logic [1:0]  sel;
        logic        sof, eof;
        int unsigned cyc;
    } res_t;

    res_t        res_q[$];
    logic [15:0] frm_q[$];
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int unsigned stalls = 0;

    always @(posedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready)
            res_q.push_back('{bus.out_max, bus.out_min, bus.out_delta, bus.out_rg, bus.out_gb,
                              bus.out_br, bus.out_sel, bus.out_sof, bus.out_eof, cyc});
        if (!rst && frame_done)
            frm_q.push_back({frame_max, frame_min});
        cyc <= cyc + 1;
    end

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic sof, input logic eof, output int unsigned acc_cyc);
        int unsigned n = 0;
        logic acc;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_r = r; bus.in_g = g; bus.in_b = b;
        bus.in_sof = sof; bus.in_eof = eof;
        forever begin
            #1;
            acc = bus.in_ready;
            acc_cyc = cyc;
            @(posedge clk);
            if (acc) break;
            stalls++;
            n++;
            if (n >= 40) begin
                checks++; errors++;
                $display("FAIL send_timeout: pixel not accepted after %0d cycles (want acceptance)", n);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        bus.in_eof = 1'b0;
    endtask

    task automatic wait_res(input int unsigned n);
        for (int i = 0; i < 40 && res_q.size() < n; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        checks++; if (bus.out_max !== 8'd0 || bus.out_min !== 8'd0 || bus.out_rg !== 9'd0)
            begin errors++; $display("FAIL rst_data: got max=%0d min=%0d rg=%0d want 0", bus.out_max, bus.out_min, bus.out_rg); end
        checks++; if (bus.out_sel !== 2'd0) begin errors++; $display("FAIL rst_sel: got %0d want 0", bus.out_sel); end
        checks++; if (frame_max !== 8'd0 || frame_min !== 8'd0)
            begin errors++; $display("FAIL rst_frame: got %0d/%0d want 0/0", frame_max, frame_min); end
    endtask

    task automatic test_basic();
        int unsigned a;
        res_q.delete();
        send(8'd200, 8'd50, 8'd100, 1'b0, 1'b0, a);
        idle();
        wait_res(1);
        checks++;
        if (res_q.size() !== 1) begin
            errors++; $display("FAIL basic_count: got %0d want 1", res_q.size());
        end else begin
            checks++; if (res_q[0].mx !== 8'd200) begin errors++; $display("FAIL basic_max: got %0d want 200", res_q[0].mx); end
            checks++; if (res_q[0].mn !== 8'd50) begin errors++; $display("FAIL basic_min: got %0d want 50", res_q[0].mn); end
            checks++; if (res_q[0].dl !== 8'd150) begin errors++; $display("FAIL basic_delta: got %0d want 150", res_q[0].dl); end
            checks++; if (res_q[0].sel !== 2'd0) begin errors++; $display("FAIL basic_sel: got %0d want 0", res_q[0].sel); end
            checks++; if (res_q[0].rg !== 9'd150) begin errors++; $display("FAIL basic_rg: got %h want 096", res_q[0].rg); end
            checks++; if (res_q[0].gb !== 9'h1CE) begin errors++; $display("FAIL basic_gb: got %h want 1ce", res_q[0].gb); end
            checks++; if (res_q[0].br !== 9'h19C) begin errors++; $display("FAIL basic_br: got %h want 19c", res_q[0].br); end
            checks++; if (res_q[0].cyc !== a + 2) begin errors++; $display("FAIL basic_latency: got %0d want %0d", res_q[0].cyc - a, 2); end
        end
    endtask

    task automatic test_ties();
        int unsigned a;
        res_q.delete();
        send(8'd80, 8'd80, 8'd80, 1'b0, 1'b0, a);
        send(8'd10, 8'd90, 8'd90, 1'b0, 1'b0, a);
        idle();
        wait_res(2);
        checks++;
        if (res_q.size() !== 2) begin
            errors++; $display("FAIL ties_count: got %0d want 2", res_q.size());
        end else begin
            checks++; if (res_q[0].sel !== 2'd0 || res_q[0].mn !== 8'd80 || res_q[0].dl !== 8'd0)
                begin errors++; $display("FAIL tie_equal: got sel=%0d min=%0d delta=%0d want 0/80/0", res_q[0].sel, res_q[0].mn, res_q[0].dl); end
            checks++; if (res_q[1].sel !== 2'd1 || res_q[1].mx !== 8'd90 || res_q[1].mn !== 8'd10)
                begin errors++; $display("FAIL tie_gb: got sel=%0d max=%0d min=%0d want 1/90/10", res_q[1].sel, res_q[1].mx, res_q[1].mn); end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned a0, a1, a2;
        res_q.delete();
        send(8'd1, 8'd2, 8'd3, 1'b0, 1'b0, a0);
        send(8'd9, 8'd8, 8'd7, 1'b0, 1'b0, a1);
        send(8'd4, 8'd6, 8'd5, 1'b0, 1'b0, a2);
        idle();
        wait_res(3);
        checks++; if (a2 !== a0 + 2) begin errors++; $display("FAIL b2b_accept: got span %0d want 2", a2 - a0); end
        checks++;
        if (res_q.size() !== 3) begin
            errors++; $display("FAIL b2b_count: got %0d want 3", res_q.size());
        end else begin
            checks++; if (res_q[2].cyc !== res_q[0].cyc + 2) begin errors++; $display("FAIL b2b_output: got span %0d want 2", res_q[2].cyc - res_q[0].cyc); end
            checks++; if (res_q[0].sel !== 2'd2 || res_q[1].sel !== 2'd0 || res_q[2].sel !== 2'd1)
                begin errors++; $display("FAIL b2b_sel: got %0d,%0d,%0d want 2,0,1", res_q[0].sel, res_q[1].sel, res_q[2].sel); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] pr [6], pg [6], pb [6], mx [6], mn [6], dl [6];
        logic [1:0] sl [6];
        pr = '{8'd10, 8'd50, 8'd5,   8'd255, 8'd60, 8'd33};
        pg = '{8'd20, 8'd40, 8'd100, 8'd0,   8'd60, 8'd34};
        pb = '{8'd30, 8'd30, 8'd7,   8'd128, 8'd70, 8'd32};
        mx = '{8'd30, 8'd50, 8'd100, 8'd255, 8'd70, 8'd34};
        mn = '{8'd10, 8'd30, 8'd5,   8'd0,   8'd60, 8'd32};
        dl = '{8'd20, 8'd20, 8'd95,  8'd255, 8'd10, 8'd2};
        sl = '{2'd2,  2'd0,  2'd1,   2'd0,   2'd2,  2'd1};
        res_q.delete();
        frm_q.delete();
        stalls = 0;
        fork
            begin
                int unsigned a;
                for (int i = 0; i < 6; i++)
                    send(pr[i], pg[i], pb[i], i == 0, i == 5, a);
                idle();
            end
            begin
                @(negedge clk);
                @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    #1;
                    checks++; if (bus.out_valid !== 1'b1 || bus.out_max !== 8'd30)
                        begin errors++; $display("FAIL bp_hold: got valid=%b max=%0d want 1/30", bus.out_valid, bus.out_max); end
                end
                @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        wait_res(6);
        checks++; if (stalls == 0) begin errors++; $display("FAIL bp_in_ready: got %0d stall cycles want >0", stalls); end
        checks++;
        if (res_q.size() !== 6) begin
            errors++; $display("FAIL bp_count: got %0d want 6", res_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (res_q[i].mx !== mx[i] || res_q[i].mn !== mn[i] || res_q[i].dl !== dl[i] || res_q[i].sel !== sl[i])
                    begin errors++; $display("FAIL bp_pix%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                        res_q[i].mx, res_q[i].mn, res_q[i].dl, res_q[i].sel, mx[i], mn[i], dl[i], sl[i]); end
            end
        end
        checks++; if (frm_q.size() !== 1 || frm_q[0] !== {8'd255, 8'd0})
            begin errors++; $display("FAIL bp_frame: got n=%0d val=%h want 1/ff00", frm_q.size(), frm_q[0]); end
    endtask

    task automatic test_frame();
        int unsigned a;
        frm_q.delete();
        res_q.delete();
        send(8'd30,  8'd5, 8'd20,  1'b1, 1'b0, a);
        send(8'd250, 8'd0, 8'd100, 1'b0, 1'b0, a);
        send(8'd40,  8'd9, 8'd20,  1'b0, 1'b1, a);
        idle();
        wait_res(3);
        checks++; if (frm_q.size() !== 1) begin errors++; $display("FAIL frame_pulses: got %0d want 1", frm_q.size()); end
        checks++; if (frame_max !== 8'd250 || frame_min !== 8'd0)
            begin errors++; $display("FAIL frame_value: got %0d/%0d want 250/0", frame_max, frame_min); end
        repeat (4) @(negedge clk);
        checks++; if (frame_max !== 8'd250 || frame_done !== 1'b0)
            begin errors++; $display("FAIL frame_hold: got max=%0d done=%b want 250/0", frame_max, frame_done); end
        send(8'd7, 8'd3, 8'd9, 1'b1, 1'b1, a);
        idle();
        wait_res(4);
        checks++; if (frm_q.size() !== 2 || frm_q[1] !== {8'd9, 8'd3})
            begin errors++; $display("FAIL frame_single: got n=%0d val=%h want 2/0903", frm_q.size(), frm_q[1]); end
    endtask

    task automatic test_reset_midstream();
        int unsigned a;
        frm_q.delete();
        res_q.delete();
        bus.out_ready = 1'b0;
        send(8'd200, 8'd1, 8'd2, 1'b1, 1'b0, a);
        send(8'd3,   8'd4, 8'd5, 1'b0, 1'b0, a);
        idle();
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
        send(8'd10, 8'd20, 8'd15, 1'b1, 1'b0, a);
        send(8'd12, 8'd11, 8'd30, 1'b0, 1'b1, a);
        idle();
        wait_res(2);
        checks++; if (res_q.size() !== 2) begin errors++; $display("FAIL midrst_count: got %0d want 2", res_q.size()); end
        checks++; if (frm_q.size() !== 1 || frm_q[0] !== {8'd30, 8'd10})
            begin errors++; $display("FAIL midrst_frame: got n=%0d val=%h want 1/1e0a", frm_q.size(), frm_q[0]); end
    endtask

    task automatic test_wide();
        @(negedge clk);
        bus12.in_valid = 1'b1;
        bus12.in_r = 12'd4095; bus12.in_g = 12'd0; bus12.in_b = 12'd4095;
        @(negedge clk);
        bus12.in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus12.out_valid !== 1'b1) begin errors++; $display("FAIL wide_valid: got %b want 1", bus12.out_valid); end
        checks++; if (bus12.out_max !== 12'd4095 || bus12.out_sel !== 2'd0 || bus12.out_min !== 12'd0)
            begin errors++; $display("FAIL wide_ext: got max=%0d sel=%0d min=%0d want 4095/0/0", bus12.out_max, bus12.out_sel, bus12.out_min); end
        checks++; if (bus12.out_rg !== 13'd4095 || bus12.out_gb !== 13'd4097 || bus12.out_br !== 13'd0)
            begin errors++; $display("FAIL wide_diff: got rg=%h gb=%h br=%h want 0fff/1001/0000", bus12.out_rg, bus12.out_gb, bus12.out_br); end
        checks++; if (bus12.out_delta !== 12'd4095) begin errors++; $display("FAIL wide_delta: got %0d want 4095", bus12.out_delta); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_r = '0; bus.in_g = '0; bus.in_b = '0;
        bus.in_sof = 1'b0; bus.in_eof = 1'b0; bus.out_ready = 1'b1;
        bus12.in_valid = 1'b0; bus12.in_r = '0; bus12.in_g = '0; bus12.in_b = '0;
        bus12.in_sof = 1'b0; bus12.in_eof = 1'b0; bus12.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_ties();
        test_back_to_back();
        test_backpressure();
        test_frame();
        test_reset_midstream();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t want finished", $time);
        $fatal(1);
    end

endmodule
